// File: rtl/oddpipe_result_stager_pkg.sv
// Shared types for the odd-pipe result stager and its forwarding lookup.
// Optional macro FWD_TAP_EN selects full forwarding; undefined gives scoreboard-only mode.
package descriptions;

  // Number of staging slots; writeback is taken from the last slot.
  localparam int DEPTH     = 7;
  // Wide enough to hold any age or latency in 1..DEPTH.
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int VAL_W     = 128;
  localparam int ADDR_W    = 7;
  localparam int LAT_IN_W  = 3;
  localparam int NUM_PORTS = 3;

  // One in-flight result. A slot with wrt_en=0 is a bubble and never matches.
  typedef struct packed {
    logic [0:VAL_W-1]  value;
    logic [0:ADDR_W-1] address;
    logic              wrt_en;
    logic [CNT_W-1:0]  latency;
    logic [CNT_W-1:0]  age;
  } stage_entry_t;

  // Outcome of one operand lookup.
  typedef struct packed {
    logic [0:VAL_W-1] value;
    logic             hit;
    logic             not_ready;
  } lookup_result_t;

  // A zero latency means "ready next cycle"; anything past DEPTH can never
  // become ready before writeback, so it is pinned to DEPTH.
  function automatic logic [CNT_W-1:0] clamp_latency(input logic [0:LAT_IN_W-1] lat);
    logic [CNT_W-1:0] res;
    if (lat == '0) begin
      res = CNT_W'(1);
    end else if (int'(lat) > DEPTH) begin
      res = CNT_W'(DEPTH);
    end else begin
      res = CNT_W'(lat);
    end
    return res;
  endfunction

endpackage

// File: rtl/oddpipe_result_stager_forward_lookup.sv
// Forwarding lookup over the staging slots for one query address.
// FWD_TAP_EN defined: youngest live match forwards when ready, else flags not_ready.
// FWD_TAP_EN undefined: any live match flags not_ready; value/hit stay 0.
module forward_lookup
  import descriptions::*;
(
  input  stage_entry_t [DEPTH:1] slots,
  input  logic [0:ADDR_W-1]      address,
  output logic [0:VAL_W-1]       value,
  output logic                   hit,
  output logic                   not_ready
);

  lookup_result_t res;

`ifdef FWD_TAP_EN
  logic found;

  // Scan from the youngest slot; the first live match decides, so an older
  // ready copy can never mask a younger result that is still in flight.
  always_comb begin
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && slots[k].wrt_en && (slots[k].address == address)) begin
        found = 1'b1;
        if (slots[k].age >= slots[k].latency) begin
          res.hit   = 1'b1;
          res.value = slots[k].value;
        end else begin
          res.not_ready = 1'b1;
        end
      end
    end
  end
`else
  logic unused_slot_bits;
  assign unused_slot_bits = ^slots;

  // Scoreboard mode: any live in-flight write to the address blocks issue.
  always_comb begin
    res = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (slots[k].wrt_en && (slots[k].address == address)) begin
        res.not_ready = 1'b1;
      end
    end
  end
`endif

  assign value     = res.value;
  assign hit       = res.hit;
  assign not_ready = res.not_ready;

endmodule

// File: rtl/oddpipe_result_stager.sv
// Odd-pipe result stager: DEPTH-slot shift pipeline to writeback with a
// three-port forwarding lookup. Optional macro FWD_TAP_EN enables forwarding;
// without it the lookups only raise stall (scoreboard-only mode).
module oddpipe_result_stager
  import descriptions::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [0:VAL_W-1]      rt_value_input,
  input  logic [0:ADDR_W-1]     rt_address_input,
  input  logic                  wrt_en_input,
  input  logic [0:LAT_IN_W-1]   latency_input,
  input  logic                  flush_input,
  input  logic [0:ADDR_W-1]     qa_address_input,
  input  logic [0:ADDR_W-1]     qb_address_input,
  input  logic [0:ADDR_W-1]     qc_address_input,
  output logic [0:VAL_W-1]      qa_value_output,
  output logic [0:VAL_W-1]      qb_value_output,
  output logic [0:VAL_W-1]      qc_value_output,
  output logic                  qa_hit_output,
  output logic                  qb_hit_output,
  output logic                  qc_hit_output,
  output logic                  stall_output,
  output logic [0:VAL_W-1]      rt_wb_value_output,
  output logic [0:ADDR_W-1]     rt_wb_address_output,
  output logic                  wrt_en_wb_output
);

  stage_entry_t [DEPTH:1] slot_q, slot_d;
  logic [0:VAL_W-1]       wb_value_q, wb_value_d;
  logic [0:ADDR_W-1]      wb_address_q, wb_address_d;
  logic                   wb_en_q, wb_en_d;

  logic [0:ADDR_W-1]      query_addr [NUM_PORTS];
  logic [0:VAL_W-1]       lk_value   [NUM_PORTS];
  logic [NUM_PORTS-1:0]   lk_hit;
  logic [NUM_PORTS-1:0]   lk_not_ready;

  // Capture the incoming result into slot 1 and shift every slot one deeper;
  // a flushed result still takes its slot but as a non-writing bubble.
  always_comb begin
    slot_d            = '0;
    slot_d[1].value   = rt_value_input;
    slot_d[1].address = rt_address_input;
    slot_d[1].wrt_en  = wrt_en_input & ~flush_input;
    slot_d[1].latency = clamp_latency(latency_input);
    slot_d[1].age     = CNT_W'(1);
    for (int k = 2; k <= DEPTH; k++) begin
      slot_d[k]     = slot_q[k-1];
      slot_d[k].age = CNT_W'(k);
    end
  end

  // Writeback stage registers whatever is leaving the last slot.
  always_comb begin
    wb_value_d   = slot_q[DEPTH].value;
    wb_address_d = slot_q[DEPTH].address;
    wb_en_d      = slot_q[DEPTH].wrt_en;
  end

  // Slot and writeback state; reset empties the pipe immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      wb_value_q   <= '0;
      wb_address_q <= '0;
      wb_en_q      <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      wb_value_q   <= wb_value_d;
      wb_address_q <= wb_address_d;
      wb_en_q      <= wb_en_d;
    end
  end

  assign query_addr[0] = qa_address_input;
  assign query_addr[1] = qb_address_input;
  assign query_addr[2] = qc_address_input;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_lookup
      forward_lookup u_lookup (
        .slots     (slot_q),
        .address   (query_addr[gi]),
        .value     (lk_value[gi]),
        .hit       (lk_hit[gi]),
        .not_ready (lk_not_ready[gi])
      );
    end
  endgenerate

  assign qa_value_output      = lk_value[0];
  assign qb_value_output      = lk_value[1];
  assign qc_value_output      = lk_value[2];
  assign qa_hit_output        = lk_hit[0];
  assign qb_hit_output        = lk_hit[1];
  assign qc_hit_output        = lk_hit[2];
  assign stall_output         = |lk_not_ready;

  assign rt_wb_value_output   = wb_value_q;
  assign rt_wb_address_output = wb_address_q;
  assign wrt_en_wb_output     = wb_en_q;

endmodule

// File: doc/oddpipe_result_stager.md
# oddpipe_result_stager

Result staging and forwarding block directly downstream of the odd pipe's first stage. Captures each odd-pipe result (value, target register, write enable, unit latency) and carries it through a fixed-depth shift pipeline to register-file writeback. Exposes a three-port forwarding lookup so the issue logic can source operands from in-flight results or stall on not-yet-ready ones.

## Interface
- DEPTH, 7, number of staging slots; writeback is taken from slot DEPTH.
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all slots.
- rt_value_input  input  [0:127]  result from odd pipe stage 1.
- rt_address_input  input  [0:6]  target register.
- wrt_en_input  input  1  result writes the register file.
- latency_input  input  [0:2]  unit latency L in cycles (valid range 1..DEPTH).
- flush_input  input  1  branch-taken kill of the entry presented this cycle.
- qa_address_input, qb_address_input, qc_address_input  input  [0:6]  operand lookup addresses.
- qa_value_output, qb_value_output, qc_value_output  output  [0:127]  forwarded value.
- qa_hit_output, qb_hit_output, qc_hit_output  output  1  forwarded value valid.
- stall_output  output  1  some lookup matches an in-flight result that is not yet ready.
- rt_wb_value_output  output  [0:127]  writeback value.
- rt_wb_address_output  output  [0:6]  writeback register.
- wrt_en_wb_output  output  1  writeback strobe.

## Operation
- Slot k (1..DEPTH) holds {value, address, wrt_en, L, age}. Each clock: slot k+1 ← slot k; slot 1 ← input, with age 1.
- Captured wrt_en = wrt_en_input & ~flush_input. Flushed entries still occupy the slot (bubble).
- latency_input 0 is treated as 1; values above DEPTH saturate to DEPTH.
- Entry is ready when age ≥ L. Age equals slot index.
- Lookup per port: consider slots with wrt_en=1 and address match. The youngest match (lowest slot index) wins.
  - Youngest match ready → hit=1, value = that slot's value.
  - Youngest match not ready → hit=0, value=0, and stall_output=1.
  - An older ready match never overrides a younger unready one.
  - No match → hit=0, value=0.
- stall_output is the OR of the three ports' not-ready conditions.
- Writeback outputs are slot DEPTH contents, registered. wrt_en_wb_output=1 only for live entries.
- Lookups and slots do not see the entry presented on the current cycle; capture precedes visibility.

## Timing
- Input captured at edge n. Visible to lookup in slot 1 from edge n to edge n+1.
- Entry reaches writeback outputs DEPTH cycles after capture.
- Lookup outputs and stall_output are combinational from slot state and query addresses.
- Reset (async, any time, including mid-stream): all slots cleared (wrt_en=0, value=0, address=0, age=0). Every output reads 0 during and immediately after reset. The first post-reset capture occurs on the first rising edge with reset low.
- flush_input asserted together with wrt_en_input: the entry becomes a bubble. Older slots are unaffected.

## Configuration
- FWD_TAP_EN defined: full forwarding; hit/value outputs behave as above.
- FWD_TAP_EN undefined: scoreboard-only mode.
  - hit and value outputs are tied to 0.
  - stall_output=1 whenever any lookup address matches any live slot, ready or not.
  - Writeback path is unchanged.

## Structure
- Package `descriptions` holds:
  - the DEPTH default constant;
  - stage_entry_t (value, address, wrt_en, latency, age);
  - a lookup_result_t struct.
- Sub-module forward_lookup: one instance per query port. Inputs are the slot array and the address; outputs are value, hit and not_ready. It is reused by the even-pipe stager.

## Test plan
- Reset mid-stream: load 3 live entries, assert reset between edges → all outputs 0 immediately; no writeback occurs afterwards.
- Writeback latency: capture value=128'd20, addr=5, wrt_en=1, L=2 at edge 0 → wrt_en_wb_output=1, addr 5, value 20 exactly after edge 7 (DEPTH=7).
- Forwarding ready/not ready: entry L=4, addr 9, value 0xAB. Query qa=9:
  - slots 1–3 → stall=1, hit=0;
  - slot 4 → hit=1, value 0xAB, stall=0.
- Youngest-wins: addr 3 with L=1, value 1 captured first; then addr 3 with L=6, value 2. Query 3 → stall=1, hit=0 until the younger entry ages 6, then value 2.
- Flush: wrt_en_input=1, flush_input=1, addr 12 → no lookup hit on 12 and no writeback; an older entry to addr 12 still forwards.
- FWD_TAP_EN undefined: repeat the ready-entry query → hit=0, value=0, stall=1 until writeback drains the slot.
